// File: rtl/div_ratio_ctrl_if.sv
// Control/status bundle for the clk_rx clock-divider controller.
// Handshake: a ratio request transfers on a clk_rx rising edge where
// req_valid && req_ready; req_div must be held stable while req_valid is high.
interface div_ratio_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             req_valid;
    logic [CNT_W-1:0] req_div;
    logic             req_ready;
    logic             err;
    logic             busy;
    logic             clk_tx;
    logic             tick;
    logic [3:0]       period_gray;
    logic [1:0]       state_dbg;

    modport master (
        output en, req_valid, req_div,
        input  req_ready, err, busy, clk_tx, tick, period_gray, state_dbg
    );

    modport slave (
        input  en, req_valid, req_div,
        output req_ready, err, busy, clk_tx, tick, period_gray, state_dbg
    );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Programmable clock-divider controller. Produces a registered divided clock
// clk_tx from clk_rx with a run-time ratio N >= 2. Ratio changes are applied
// only on a period boundary and enable changes always let the current period
// finish, so clk_tx never shows a runt level. A Gray-coded period count is
// exported for sampling in another clock domain.
module div_ratio_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic            clk_rx,
    input  logic            rst_n,
    div_ratio_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] nxt_div_q, nxt_div_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [3:0]       pc_q, pc_d;
    logic             ready_en_q;
    logic             clk_tx_q, clk_tx_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [3:0]       gray_q, gray_d;

    logic             req_ready;
    logic             accept;
    logic             req_ok;
    logic             last_cyc;
    logic             run_d;

    // Ready is held low through reset and while a ratio is already pending.
    assign req_ready = ready_en_q && (state_q != ST_PEND);
    assign accept    = bus.req_valid && req_ready;
    assign req_ok    = (bus.req_div >= DIV_MIN);
    assign last_cyc  = (phase_q == (cur_div_q - ONE));

    // Next-state logic: phase counting, ratio loading and run/stop decisions.
    always_comb begin
        state_d   = state_q;
        cur_div_d = cur_div_q;
        nxt_div_d = nxt_div_q;
        phase_d   = phase_q;
        err_d     = accept && !req_ok;

        case (state_q)
            ST_STOP: begin
                phase_d = '0;
                // No period is in flight, so a legal ratio applies at once.
                if (accept && req_ok) begin
                    cur_div_d = bus.req_div;
                end
                if (bus.en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (last_cyc) begin
                    phase_d = '0;
                    if (state_q == ST_PEND) begin
                        cur_div_d = nxt_div_q;
                    end
                    // A request landing on the last cycle is already on the
                    // boundary; only reachable from RUN since PEND blocks ready.
                    if (accept && req_ok) begin
                        cur_div_d = bus.req_div;
                    end
                    state_d = bus.en ? ST_RUN : ST_STOP;
                end else begin
                    phase_d = phase_q + ONE;
                    if (accept && req_ok) begin
                        nxt_div_d = bus.req_div;
                        state_d   = ST_PEND;
                    end
                end
            end

            default: begin
                state_d = ST_STOP;
                phase_d = '0;
            end
        endcase
    end

    // Output pre-computation from the next state so the registered outputs
    // line up with the phase they describe.
    always_comb begin
        run_d    = (state_d != ST_STOP);
        clk_tx_d = run_d && (phase_d < (cur_div_d >> 1));
        tick_d   = run_d && (phase_d == '0);
        pc_d     = pc_q + {3'b000, tick_d};
        gray_d   = pc_d ^ (pc_d >> 1);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_rx) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            cur_div_q  <= DIV_RST;
            nxt_div_q  <= DIV_RST;
            phase_q    <= '0;
            pc_q       <= '0;
            ready_en_q <= 1'b0;
            clk_tx_q   <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            gray_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            nxt_div_q  <= nxt_div_d;
            phase_q    <= phase_d;
            pc_q       <= pc_d;
            ready_en_q <= 1'b1;
            clk_tx_q   <= clk_tx_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            gray_q     <= gray_d;
        end
    end

    // Status outputs; busy tracks the current state with no register stage.
    always_comb begin
        bus.req_ready   = req_ready;
        bus.busy        = (state_q != ST_STOP);
        bus.err         = err_q;
        bus.clk_tx      = clk_tx_q;
        bus.tick        = tick_q;
        bus.period_gray = gray_q;
        bus.state_dbg   = state_q;
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl. Driver tasks push the expected output
// vector for each clk_rx cycle into exp_q; a negedge monitor pops and compares.
// Vector layout: {clk_tx, tick, busy, req_ready, err, period_gray[3:0]}.
module tb_div_ratio_ctrl;
    localparam int CNT_W = 8;
    localparam int W     = 9;

    logic clk_rx = 1'b0;
    logic rst_n  = 1'b0;

    div_ratio_ctrl_if #(.CNT_W(CNT_W)) bus ();

    div_ratio_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
        .clk_rx (clk_rx),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Clock / reset
    always #5 clk_rx = ~clk_rx;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           passed = 0;
    int           exp_pc = 0;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    always @(negedge clk_rx) begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        string        t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {bus.clk_tx, bus.tick, bus.busy, bus.req_ready, bus.err, bus.period_gray};
            checks++;
            if (act !== e)
                $display("FAIL %s: got clk/tick/busy/rdy/err/gray=%b_%h required %b_%h",
                         t, act[8:4], act[3:0], e[8:4], e[3:0]);
            else
                passed++;
        end
    end

    // Driver tasks
    task automatic cyc(input logic [W-1:0] e, input string t);
        @(posedge clk_rx);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic reset_cycle(input string t);
        cyc({5'b00000, 4'h0}, t);
    endtask

    task automatic idle(input int n, input string t);
        for (int i = 0; i < n; i++)
            cyc({4'b0001, 1'b0, gray_tab[exp_pc % 16]}, $sformatf("%s idle%0d", t, i));
    endtask

    // Ratio request issued while stopped; err is expected the following cycle.
    task automatic stop_req(input int div, input string t);
        bus.req_valid = 1'b1;
        bus.req_div   = CNT_W'(div);
        cyc({4'b0001, (div < 2), gray_tab[exp_pc % 16]}, $sformatf("%s stopreq%0d", t, div));
        bus.req_valid = 1'b0;
    endtask

    // One clk_tx period of n cycles (truncated to len). Optional request
    // during phase req_at, en forced low at phase en_off_at and high at en_on_at.
    task automatic period(input string t, input int n, input int len, input int req_at,
                          input int rdiv, input int en_off_at, input int en_on_at);
        int pend_from;
        int err_at;
        logic [W-1:0] e;
        pend_from = n;
        err_at    = -1;
        if (req_at >= 0 && req_at < n - 1) begin
            if (rdiv >= 2) pend_from = req_at + 1;
            else           err_at    = req_at + 1;
        end
        for (int k = 0; k < len; k++) begin
            if (k == 0) exp_pc++;
            e = {(k < n / 2), (k == 0), 1'b1, (k < pend_from), (k == err_at),
                 gray_tab[exp_pc % 16]};
            cyc(e, $sformatf("%s n=%0d ph=%0d", t, n, k));
            bus.req_valid = (k == req_at);
            bus.req_div   = CNT_W'(rdiv);
            if (k == en_off_at) bus.en = 1'b0;
            if (k == en_on_at)  bus.en = 1'b1;
        end
    endtask

    // Stimulus
    initial begin
        bus.en        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_div   = '0;

        // Reset values, then ready rises in the first cycle after release.
        repeat (3) reset_cycle("reset");
        rst_n = 1'b1;
        idle(2, "post_reset");

        // Default ratio 2: full Gray sequence wraps back to 0 after 16 periods.
        bus.en = 1'b1;
        for (int p = 0; p < 15; p++) period("div2", 2, 2, -1, 0, -1, -1);
        period("div2_last", 2, 2, -1, 0, 0, -1);
        idle(2, "div2_stop");

        // N=9 (4 high/5 low) then N=80 (40/40), loaded while stopped.
        stop_req(9, "n9");
        bus.en = 1'b1;
        period("n9", 9, 9, -1, 0, -1, -1);
        period("n9", 9, 9, -1, 0, 0, -1);
        idle(1, "n9_stop");
        stop_req(80, "n80");
        bus.en = 1'b1;
        period("n80", 80, 80, -1, 0, -1, -1);
        period("n80", 80, 80, -1, 0, 0, -1);
        idle(1, "n80_stop");

        // Switch 12 -> 9 requested at phase 3; then a last-cycle request 9 -> 12.
        stop_req(12, "sw");
        bus.en = 1'b1;
        period("sw_pend", 12, 12, 3, 9, -1, -1);
        period("sw_new", 9, 9, -1, 0, -1, -1);
        period("sw_last", 9, 9, 8, 12, -1, -1);

        // Illegal ratios while running: err pulse, no state change.
        period("bad1", 12, 12, 5, 1, -1, -1);
        period("bad0", 12, 12, 2, 0, -1, -1);

        // Drop en at phase 2: period completes, then STOP.
        period("en_drop", 12, 12, -1, 0, 2, -1);
        idle(3, "en_drop");
        stop_req(1, "bad_stop");
        idle(1, "bad_stop");

        // Drop then reassert en before the last cycle: no gap.
        bus.en = 1'b1;
        period("en_bounce", 12, 12, -1, 0, 2, 8);
        period("en_bounce_next", 12, 12, -1, 0, 0, -1);
        idle(2, "en_bounce");

        // Reset in PEND with 80 pending: pending ratio lost, back to DEFAULT_DIV.
        bus.en = 1'b1;
        period("pend_rst", 12, 7, 3, 80, -1, -1);
        rst_n = 1'b0;
        reset_cycle("mid_reset0");
        reset_cycle("mid_reset1");
        exp_pc = 0;
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) period("after_rst", 2, 2, -1, 0, -1, -1);
        period("after_rst_last", 2, 2, -1, 0, 0, -1);
        idle(2, "after_rst");

        // Drain: every expected vector must have been consumed.
        @(negedge clk_rx);
        #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion required completion");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $finish;
    end

endmodule
